trapez_energy_reader: RTL and testbench

- Consumes the trapezoidal shaper output stream and extracts one pulse-height (energy) value per accepted trigger.
- Sits directly downstream of the shaper and upstream of the histogram/readout logic.
- Waits a programmable peaking delay after pulse_time, then averages 2^avg_log2 flat-top samples.
- Rejects pile-up and delivers each result through a valid/ready handshake.

---
 rtl/trapez_energy_reader_if.sv | 21 ++
 rtl/trapez_energy_reader.sv | 187 ++++++++++++++++++
 tb/tb_trapez_energy_reader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/trapez_energy_reader_if.sv
// Result handshake bundle between the energy reader and the readout logic.
// The master drives data/valid, the slave answers with ready.
interface trapez_energy_reader_if #(
    parameter int DATA_W = 16
) ();
    logic [DATA_W-1:0] energy_data;
    logic              energy_valid;
    logic              energy_ready;

    modport master (
        output energy_data,
        output energy_valid,
        input  energy_ready
    );

    modport slave (
        input  energy_data,
        input  energy_valid,
        output energy_ready
    );
endinterface

// File: rtl/trapez_energy_reader.sv
// Extracts one averaged flat-top amplitude per trigger from the shaper stream.
// Optional baseline subtraction: define TRAPEZ_ENERGY_BASELINE_EN.
module trapez_energy_reader #(
    parameter int SIZE_SHAPER_DATA     = 16,
    parameter int SIZE_SHAPER_CONSTANT = 10,
    parameter int SIZE_LOST_CNT        = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [SIZE_SHAPER_DATA-1:0]     shaper_data,
    input  logic                            shaper_valid,
    input  logic                            pulse_time,
    input  logic [SIZE_SHAPER_CONSTANT-1:0] peak_delay,
    input  logic [2:0]                      avg_log2,
    input  logic [SIZE_SHAPER_CONSTANT-1:0] holdoff,
    trapez_energy_reader_if.master          energy,
    output logic                            pileup_flag,
    output logic [SIZE_LOST_CNT-1:0]        lost_count,
    output logic                            busy
`ifdef TRAPEZ_ENERGY_BASELINE_EN
    ,
    output logic [SIZE_SHAPER_DATA-1:0]     baseline_data
`endif
);
    localparam int SD = SIZE_SHAPER_DATA;
    localparam int SC = SIZE_SHAPER_CONSTANT;
    localparam int AW = SD + 7;
    // counter must also reach the 128-sample window
    localparam int CW = (SC > 8) ? SC : 8;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        ACCUM,
        HOLDOFF
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n, cnt_inc;
    logic [CW-1:0]   pd_ext, ho_ext, win;
    logic [SC-1:0]   pd_q, ho_q;
    logic [2:0]      al_q;
    logic [AW-1:0]   acc, acc_n, acc_sum;
    logic [SD-1:0]   avg, result;
    logic            latch, fire, pile;

    assign cnt_inc = cnt + CW'(1);
    assign pd_ext  = CW'(pd_q);
    assign ho_ext  = CW'(ho_q);
    assign win     = CW'(1) << al_q;
    assign acc_sum = acc + AW'(shaper_data);
    assign avg     = SD'(acc_sum >> al_q);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        acc_n   = acc;
        latch   = 1'b0;
        fire    = 1'b0;
        pile    = 1'b0;
        if (!enable) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pulse_time) begin
                        latch   = 1'b1;
                        cnt_n   = '0;
                        acc_n   = '0;
                        state_n = (peak_delay != '0) ? DELAY : ACCUM;
                    end
                end
                DELAY: begin
                    if (pulse_time) begin
                        pile = 1'b1;
                    end else if (shaper_valid) begin
                        if (cnt_inc == pd_ext) begin
                            cnt_n   = '0;
                            state_n = ACCUM;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end
                end
                ACCUM: begin
                    // a trigger on the final sample discards the result
                    if (pulse_time) begin
                        pile = 1'b1;
                    end else if (shaper_valid) begin
                        acc_n = acc_sum;
                        if (cnt_inc == win) begin
                            fire    = 1'b1;
                            state_n = IDLE;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end
                end
                HOLDOFF: begin
                    if (pulse_time) begin
                        cnt_n = '0;
                    end else if (shaper_valid) begin
                        if (cnt_inc == ho_ext) begin
                            state_n = IDLE;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
            if (pile) begin
                cnt_n   = '0;
                state_n = (ho_q != '0) ? HOLDOFF : IDLE;
            end
        end
    end

`ifdef TRAPEZ_ENERGY_BASELINE_EN
    localparam int BW = SD + 5;

    logic signed [BW-1:0] base_q;
    logic signed [BW:0]   diff;
    logic signed [SD+1:0] delta;

    assign diff  = $signed({2'b00, shaper_data, 4'b0000})
                 - $signed({base_q[BW-1], base_q});
    assign delta = $signed({2'b00, avg})
                 - $signed({base_q[BW-1], base_q[BW-1:4]});
    assign result        = delta[SD+1] ? '0 : delta[SD-1:0];
    assign baseline_data = base_q[SD+3:4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q <= '0;
        end else if (state == IDLE && shaper_valid) begin
            base_q <= base_q + BW'(diff >>> 4);
        end
    end
`else
    assign result = avg;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            pd_q        <= '0;
            ho_q        <= '0;
            al_q        <= '0;
            pileup_flag <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            acc         <= acc_n;
            pileup_flag <= pile;
            busy        <= (state_n != IDLE);
            if (latch) begin
                pd_q <= peak_delay;
                ho_q <= holdoff;
                al_q <= avg_log2;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            energy.energy_data  <= '0;
            energy.energy_valid <= 1'b0;
            lost_count          <= '0;
        end else if (fire) begin
            if (energy.energy_valid && !energy.energy_ready) begin
                if (lost_count != '1) begin
                    lost_count <= lost_count + SIZE_LOST_CNT'(1);
                end
            end else begin
                energy.energy_data  <= result;
                energy.energy_valid <= 1'b1;
            end
        end else if (energy.energy_valid && energy.energy_ready) begin
            energy.energy_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_trapez_energy_reader.sv
// Directed bench for trapez_energy_reader (default build).
// Expected values are hand-computed constants.
module tb_trapez_energy_reader;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] shaper_data;
    logic        shaper_valid;
    logic        pulse_time;
    logic [9:0]  peak_delay;
    logic [2:0]  avg_log2;
    logic [9:0]  holdoff;
    logic        pileup_flag;
    logic [15:0] lost_count;
    logic        busy;
`ifdef TRAPEZ_ENERGY_BASELINE_EN
    logic [15:0] baseline_data;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] ft [128];

    trapez_energy_reader_if #(.DATA_W(16)) eif ();

    trapez_energy_reader dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .shaper_data  (shaper_data),
        .shaper_valid (shaper_valid),
        .pulse_time   (pulse_time),
        .peak_delay   (peak_delay),
        .avg_log2     (avg_log2),
        .holdoff      (holdoff),
        .energy       (eif),
        .pileup_flag  (pileup_flag),
        .lost_count   (lost_count),
        .busy         (busy)
`ifdef TRAPEZ_ENERGY_BASELINE_EN
        ,
        .baseline_data(baseline_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [15:0] d,
                       input logic pt);
        shaper_valid = v;
        shaper_data  = d;
        pulse_time   = pt;
        @(posedge clk);
        #1;
        pulse_time   = 1'b0;
        shaper_valid = 1'b0;
    endtask

    // trigger, pd delay samples, 2^al flat-top samples from ft
    task automatic run_event(input int pd, input int al, input int gap,
                             input logic rdy_last);
        int n;
        n = 1 << al;
        peak_delay = 10'(pd);
        avg_log2   = 3'(al);
        cyc(1'b1, 16'h7777, 1'b1);
        peak_delay = 10'd9;
        avg_log2   = 3'd1;
        for (int i = 0; i < pd; i++) begin
            for (int g = 0; g < gap; g++) cyc(1'b0, 16'hEEEE, 1'b0);
            cyc(1'b1, 16'h1111, 1'b0);
        end
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) cyc(1'b0, 16'hEEEE, 1'b0);
            if (i == n - 1) eif.energy_ready = rdy_last;
            cyc(1'b1, ft[i], 1'b0);
        end
    endtask

    task automatic set_ft(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
        ft[0] = a;
        ft[1] = b;
        ft[2] = c;
        ft[3] = d;
    endtask

    initial begin
        reset            = 1'b0;
        enable           = 1'b1;
        shaper_data      = '0;
        shaper_valid     = 1'b0;
        pulse_time       = 1'b0;
        peak_delay       = 10'd4;
        avg_log2         = 3'd2;
        holdoff          = 10'd10;
        eif.energy_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", 32'(eif.energy_data), 32'h0);
        check("rst_valid", 32'(eif.energy_valid), 32'h0);
        check("rst_pileup", 32'(pileup_flag), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_lost", 32'(lost_count), 32'h0);
        reset = 1'b1;
        cyc(1'b0, 16'h0, 1'b0);

        // basic event, ready high
        set_ft(16'd100, 16'd102, 16'd98, 16'd100);
        run_event(4, 2, 0, 1'b1);
        check("t1_valid", 32'(eif.energy_valid), 32'h1);
        check("t1_data", 32'(eif.energy_data), 32'd100);
        check("t1_busy", 32'(busy), 32'h0);
        cyc(1'b0, 16'h0, 1'b0);
        check("t1_valid_1cyc", 32'(eif.energy_valid), 32'h0);

        // same event with invalid gaps
        run_event(4, 2, 1, 1'b1);
        check("t2_valid", 32'(eif.energy_valid), 32'h1);
        check("t2_data", 32'(eif.energy_data), 32'd100);
        cyc(1'b0, 16'h0, 1'b0);
        check("t2_valid_drop", 32'(eif.energy_valid), 32'h0);

        // pile-up in ACCUM, holdoff 10, retrigger extends it
        holdoff    = 10'd10;
        peak_delay = 10'd4;
        avg_log2   = 3'd2;
        cyc(1'b1, 16'h7777, 1'b1);
        repeat (4) cyc(1'b1, 16'h1111, 1'b0);
        repeat (2) cyc(1'b1, 16'd100, 1'b0);
        cyc(1'b1, 16'd100, 1'b1);
        check("t3_pileup", 32'(pileup_flag), 32'h1);
        check("t3_busy", 32'(busy), 32'h1);
        cyc(1'b1, 16'h0, 1'b0);
        check("t3_pileup_1cyc", 32'(pileup_flag), 32'h0);
        repeat (2) cyc(1'b1, 16'h0, 1'b0);
        cyc(1'b1, 16'h0, 1'b1);
        check("t3_retrig_nopile", 32'(pileup_flag), 32'h0);
        repeat (9) cyc(1'b1, 16'h0, 1'b0);
        check("t3_busy_9", 32'(busy), 32'h1);
        cyc(1'b1, 16'h0, 1'b0);
        check("t3_busy_10", 32'(busy), 32'h0);
        check("t3_no_result", 32'(eif.energy_valid), 32'h0);

        // trigger on final sample, holdoff 0 -> straight to IDLE
        holdoff = 10'd0;
        cyc(1'b1, 16'h7777, 1'b1);
        repeat (4) cyc(1'b1, 16'h1111, 1'b0);
        repeat (3) cyc(1'b1, 16'd100, 1'b0);
        cyc(1'b1, 16'd100, 1'b1);
        check("t4_pileup", 32'(pileup_flag), 32'h1);
        check("t4_busy", 32'(busy), 32'h0);
        check("t4_no_result", 32'(eif.energy_valid), 32'h0);
        holdoff = 10'd10;

        // enable drop aborts silently
        cyc(1'b1, 16'h7777, 1'b1);
        repeat (2) cyc(1'b1, 16'h1111, 1'b0);
        enable = 1'b0;
        cyc(1'b1, 16'h0, 1'b0);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_pileup", 32'(pileup_flag), 32'h0);
        enable = 1'b1;
        repeat (8) cyc(1'b1, 16'd100, 1'b0);
        check("t5_no_result", 32'(eif.energy_valid), 32'h0);

        // backpressure: second result dropped
        eif.energy_ready = 1'b0;
        run_event(4, 2, 0, 1'b0);
        check("t6_a_valid", 32'(eif.energy_valid), 32'h1);
        check("t6_a_data", 32'(eif.energy_data), 32'd100);
        set_ft(16'd200, 16'd200, 16'd200, 16'd200);
        run_event(4, 2, 0, 1'b0);
        check("t6_held_data", 32'(eif.energy_data), 32'd100);
        check("t6_held_valid", 32'(eif.energy_valid), 32'h1);
        check("t6_lost", 32'(lost_count), 32'd1);
        eif.energy_ready = 1'b1;
        cyc(1'b0, 16'h0, 1'b0);
        check("t6_accept", 32'(eif.energy_valid), 32'h0);

        // new result on the handshake cycle is loaded
        eif.energy_ready = 1'b0;
        set_ft(16'd100, 16'd102, 16'd98, 16'd100);
        run_event(4, 2, 0, 1'b0);
        set_ft(16'd300, 16'd304, 16'd296, 16'd300);
        run_event(4, 2, 0, 1'b1);
        check("t7_valid", 32'(eif.energy_valid), 32'h1);
        check("t7_data", 32'(eif.energy_data), 32'd300);
        check("t7_lost", 32'(lost_count), 32'd1);
        cyc(1'b0, 16'h0, 1'b0);
        check("t7_drop", 32'(eif.energy_valid), 32'h0);

        // 128-sample window of full scale, zero peak delay
        for (int i = 0; i < 128; i++) ft[i] = 16'hFFFF;
        run_event(0, 7, 0, 1'b1);
        check("t8_valid", 32'(eif.energy_valid), 32'h1);
        check("t8_data", 32'(eif.energy_data), 32'hFFFF);
        cyc(1'b0, 16'h0, 1'b0);

        // async reset mid-ACCUM with a held result
        eif.energy_ready = 1'b0;
        set_ft(16'd100, 16'd102, 16'd98, 16'd100);
        run_event(4, 2, 0, 1'b0);
        cyc(1'b1, 16'h7777, 1'b1);
        repeat (4) cyc(1'b1, 16'h1111, 1'b0);
        repeat (2) cyc(1'b1, 16'd100, 1'b0);
        check("t9_pre_valid", 32'(eif.energy_valid), 32'h1);
        #3;
        reset = 1'b0;
        #1;
        check("t9_data", 32'(eif.energy_data), 32'h0);
        check("t9_valid", 32'(eif.energy_valid), 32'h0);
        check("t9_busy", 32'(busy), 32'h0);
        check("t9_lost", 32'(lost_count), 32'h0);
        #2;
        reset = 1'b1;
        eif.energy_ready = 1'b1;
        @(posedge clk);
        #1;
        set_ft(16'd50, 16'd54, 16'd50, 16'd46);
        run_event(4, 2, 0, 1'b1);
        check("t9_fresh_valid", 32'(eif.energy_valid), 32'h1);
        check("t9_fresh_data", 32'(eif.energy_data), 32'd50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
